// File: rtl/enemy_formation_ctrl.sv
// rtl/enemy_formation_ctrl.sv - formation march sequencer driving erase/draw passes into the sprite drawer
module enemy_formation_ctrl #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int SPACING_X   = 16,
    parameter int SPACING_Y   = 12,
    parameter int SPR_W       = 12,
    parameter int SPR_H       = 8,
    parameter int STEP        = 2,
    parameter int DROP        = 8,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 319,
    parameter int Y_LIMIT     = 200,
    parameter int START_X     = 20,
    parameter int START_Y     = 30,
    parameter int MOVE_PERIOD = 1666666
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] alive,
    output logic [8:0]           spr_x,
    output logic [7:0]           spr_y,
    output logic                 spr_erase,
    output logic                 spr_start,
    input  logic                 spr_done,
    output logic [8:0]           origin_x,
    output logic [7:0]           origin_y,
    output logic                 busy,
    output logic                 invaded
);
    localparam int N          = ROWS * COLS;
    localparam int IW         = $clog2(N);
    localparam int CW         = $clog2(MOVE_PERIOD + 1);
    localparam int RIGHT_SPAN = (COLS - 1) * SPACING_X + SPR_W - 1 + STEP;
    localparam int BOTTOM     = (ROWS - 1) * SPACING_Y + SPR_H - 1;

    typedef enum logic [2:0] {
        IDLE, ERASE_ISSUE, ERASE_WAIT, MOVE, DRAW_ISSUE, DRAW_WAIT, HALT
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic [N-1:0]    snapshot, snapshot_nxt;
    logic [8:0]      origin_x_nxt, spr_x_nxt, cur_x;
    logic [7:0]      origin_y_nxt, spr_y_nxt, cur_y;
    logic            dir_left, dir_left_nxt;
    logic            spr_erase_nxt, spr_start_nxt, invaded_nxt;
    logic            last, bottom_hit;

    assign cur_x      = origin_x + 9'(((32'(idx) % COLS) * SPACING_X));
    assign cur_y      = origin_y + 8'(((32'(idx) / COLS) * SPACING_Y));
    assign last       = (idx == IW'(N - 1));
    assign bottom_hit = (32'(origin_y) + BOTTOM) >= Y_LIMIT;
    assign busy       = (state != IDLE) && (state != HALT);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            snapshot  <= '0;
            origin_x  <= 9'(START_X);
            origin_y  <= 8'(START_Y);
            dir_left  <= 1'b0;
            spr_x     <= '0;
            spr_y     <= '0;
            spr_erase <= 1'b0;
            spr_start <= 1'b0;
            invaded   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            idx       <= idx_nxt;
            snapshot  <= snapshot_nxt;
            origin_x  <= origin_x_nxt;
            origin_y  <= origin_y_nxt;
            dir_left  <= dir_left_nxt;
            spr_x     <= spr_x_nxt;
            spr_y     <= spr_y_nxt;
            spr_erase <= spr_erase_nxt;
            spr_start <= spr_start_nxt;
            invaded   <= invaded_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        idx_nxt       = idx;
        snapshot_nxt  = snapshot;
        origin_x_nxt  = origin_x;
        origin_y_nxt  = origin_y;
        dir_left_nxt  = dir_left;
        spr_x_nxt     = spr_x;
        spr_y_nxt     = spr_y;
        spr_erase_nxt = spr_erase;
        spr_start_nxt = 1'b0;
        invaded_nxt   = invaded;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (cnt == CW'(MOVE_PERIOD - 1)) begin
                        cnt_nxt      = '0;
                        snapshot_nxt = alive;
                        idx_nxt      = '0;
                        state_nxt    = ERASE_ISSUE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            ERASE_ISSUE: begin
                if (snapshot[idx]) begin
                    spr_x_nxt     = cur_x;
                    spr_y_nxt     = cur_y;
                    spr_erase_nxt = 1'b1;
                    spr_start_nxt = 1'b1;
                    state_nxt     = ERASE_WAIT;
                end else if (last) begin
                    state_nxt = MOVE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            ERASE_WAIT: begin
                if (spr_done) begin
                    if (last) begin
                        state_nxt = MOVE;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = ERASE_ISSUE;
                    end
                end
            end
            MOVE: begin
                // A bounce drops the formation without moving it sideways this tick.
                if (!dir_left) begin
                    if ((32'(origin_x) + RIGHT_SPAN) > X_MAX) begin
                        origin_y_nxt = origin_y + 8'(DROP);
                        dir_left_nxt = 1'b1;
                    end else begin
                        origin_x_nxt = origin_x + 9'(STEP);
                    end
                end else begin
                    if (32'(origin_x) < (X_MIN + STEP)) begin
                        origin_y_nxt = origin_y + 8'(DROP);
                        dir_left_nxt = 1'b0;
                    end else begin
                        origin_x_nxt = origin_x - 9'(STEP);
                    end
                end
                idx_nxt   = '0;
                state_nxt = DRAW_ISSUE;
            end
            DRAW_ISSUE: begin
                // Live mask is re-sampled here so enemies killed mid-tick are not redrawn.
                if (snapshot[idx] && alive[idx]) begin
                    spr_x_nxt     = cur_x;
                    spr_y_nxt     = cur_y;
                    spr_erase_nxt = 1'b0;
                    spr_start_nxt = 1'b1;
                    state_nxt     = DRAW_WAIT;
                end else if (last) begin
                    state_nxt   = bottom_hit ? HALT : IDLE;
                    invaded_nxt = invaded | bottom_hit;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DRAW_WAIT: begin
                if (spr_done) begin
                    if (last) begin
                        state_nxt   = bottom_hit ? HALT : IDLE;
                        invaded_nxt = invaded | bottom_hit;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        state_nxt = DRAW_ISSUE;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// tb/tb_enemy_formation_ctrl.sv - directed self-checking bench for enemy_formation_ctrl
module tb_enemy_formation_ctrl;
    logic        clock = 1'b0;
    logic [3:0]  rst   = 4'h0;
    logic [3:0]  en    = 4'h0;
    logic [3:0]  done  = 4'h0;
    logic [3:0]  start, erase, busy, inv;
    logic [8:0]  sx [4];
    logic [7:0]  sy [4];
    logic [8:0]  ox [4];
    logic [7:0]  oy [4];
    logic [31:0] alive [4];

    int          checks = 0;
    int          errors = 0;
    int          rcnt [4] = '{0, 0, 0, 0};
    int          st_cnt [4] = '{0, 0, 0, 0};
    int          npass [4] = '{0, 0, 0, 0};
    logic [16:0] hist [4][8];
    logic [3:0]  busy_prev = 4'h0;
    logic [17:0] rq [$];
    int          cyc;
    int          draws;
    int          base;

    always #5 clock = ~clock;

    enemy_formation_ctrl #(.MOVE_PERIOD(4)) u0 (
        .clock(clock), .resetn(rst[0]), .enable(en[0]), .alive(alive[0]),
        .spr_x(sx[0]), .spr_y(sy[0]), .spr_erase(erase[0]), .spr_start(start[0]),
        .spr_done(done[0]), .origin_x(ox[0]), .origin_y(oy[0]), .busy(busy[0]), .invaded(inv[0]));

    enemy_formation_ctrl #(.MOVE_PERIOD(4), .START_X(194), .START_Y(150)) u1 (
        .clock(clock), .resetn(rst[1]), .enable(en[1]), .alive(alive[1]),
        .spr_x(sx[1]), .spr_y(sy[1]), .spr_erase(erase[1]), .spr_start(start[1]),
        .spr_done(done[1]), .origin_x(ox[1]), .origin_y(oy[1]), .busy(busy[1]), .invaded(inv[1]));

    enemy_formation_ctrl #(.MOVE_PERIOD(4), .START_X(194)) u2 (
        .clock(clock), .resetn(rst[2]), .enable(en[2]), .alive(alive[2]),
        .spr_x(sx[2]), .spr_y(sy[2]), .spr_erase(erase[2]), .spr_start(start[2]),
        .spr_done(done[2]), .origin_x(ox[2]), .origin_y(oy[2]), .busy(busy[2]), .invaded(inv[2]));

    enemy_formation_ctrl #(.MOVE_PERIOD(4), .START_X(1), .X_MAX(125)) u3 (
        .clock(clock), .resetn(rst[3]), .enable(en[3]), .alive(alive[3]),
        .spr_x(sx[3]), .spr_y(sy[3]), .spr_erase(erase[3]), .spr_start(start[3]),
        .spr_done(done[3]), .origin_x(ox[3]), .origin_y(oy[3]), .busy(busy[3]), .invaded(inv[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_busy(input int k, input logic level, input int limit, output int n);
        n = 0;
        while (busy[k] !== level && n < limit) begin
            @(negedge clock);
            n++;
        end
    endtask

    // Drawer model: done pulse two cycles after each request.
    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
            done[k] = 1'b0;
            if (rcnt[k] > 0) begin
                rcnt[k]--;
                if (rcnt[k] == 0) done[k] = 1'b1;
            end
            if (start[k] === 1'b1) rcnt[k] = 2;
        end
    end

    always @(negedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (start[k] === 1'b1) st_cnt[k]++;
            if (busy_prev[k] && !busy[k]) begin
                if (npass[k] < 8) hist[k][npass[k]] = {ox[k], oy[k]};
                npass[k]++;
            end
        end
        busy_prev = busy;
        if (start[0] === 1'b1) rq.push_back({erase[0], sx[0], sy[0]});
    end

    initial begin
        alive[0] = 32'h5;
        alive[1] = 32'h1;
        alive[2] = 32'h0;
        alive[3] = 32'h0;
        repeat (2) @(negedge clock);
        check("rst_busy_in_reset", {31'd0, busy[0]}, 32'd0);
        check("rst_origin_in_reset", {15'd0, ox[0], oy[0]}, {15'd0, 9'd20, 8'd30});
        rst = 4'hf;
        @(negedge clock);
        check("rst_start", {31'd0, start[0]}, 32'd0);
        check("rst_erase", {31'd0, erase[0]}, 32'd0);
        check("rst_spr_xy", {15'd0, sx[0], sy[0]}, 32'd0);
        check("rst_invaded", {31'd0, inv[0]}, 32'd0);
        check("rst_origin", {15'd0, ox[0], oy[0]}, {15'd0, 9'd20, 8'd30});
        check("idle_no_enable", {31'd0, busy[0]}, 32'd0);
        en[3:1] = 3'b111;

        en[0] = 1'b1;
        wait_busy(0, 1'b1, 20, cyc);
        en[0] = 1'b0;
        check("tick_latency", cyc, 4);
        wait_busy(0, 1'b0, 300, cyc);
        check("basic_idle_again", {31'd0, busy[0]}, 32'd0);
        check("basic_nreq", rq.size(), 4);
        if (rq.size() == 4) begin
            check("basic_erase0", {14'd0, rq[0]}, {14'd0, 1'b1, 9'd20, 8'd30});
            check("basic_erase2", {14'd0, rq[1]}, {14'd0, 1'b1, 9'd52, 8'd30});
            check("basic_draw0", {14'd0, rq[2]}, {14'd0, 1'b0, 9'd22, 8'd30});
            check("basic_draw2", {14'd0, rq[3]}, {14'd0, 1'b0, 9'd54, 8'd30});
        end
        check("basic_origin", {15'd0, ox[0], oy[0]}, {15'd0, 9'd22, 8'd30});

        rq.delete();
        en[0] = 1'b1;
        wait_busy(0, 1'b1, 20, cyc);
        en[0] = 1'b0;
        cyc = 0;
        while (start[0] !== 1'b1 && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        check("kill_first_req", {31'd0, start[0]}, 32'd1);
        alive[0] = 32'h1;
        wait_busy(0, 1'b0, 300, cyc);
        check("kill_nreq", rq.size(), 3);
        draws = 0;
        foreach (rq[i]) if (!rq[i][17]) draws++;
        check("kill_ndraw", draws, 1);
        if (rq.size() == 3) begin
            check("kill_erase2", {14'd0, rq[1]}, {14'd0, 1'b1, 9'd54, 8'd30});
            check("kill_draw0", {14'd0, rq[2]}, {14'd0, 1'b0, 9'd24, 8'd30});
        end
        check("kill_origin", {15'd0, ox[0], oy[0]}, {15'd0, 9'd24, 8'd30});
        alive[0] = 32'h5;

        rq.delete();
        en[0] = 1'b1;
        wait_busy(0, 1'b1, 20, cyc);
        en[0] = 1'b0;
        cyc = 0;
        while (!(start[0] === 1'b1 && erase[0] === 1'b0) && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check("rstmid_draw_seen", {31'd0, start[0]}, 32'd1);
        @(negedge clock);
        rst[0] = 1'b0;
        #1;
        check("rstmid_start", {31'd0, start[0]}, 32'd0);
        check("rstmid_busy", {31'd0, busy[0]}, 32'd0);
        check("rstmid_origin", {15'd0, ox[0], oy[0]}, {15'd0, 9'd20, 8'd30});
        #1;
        rst[0] = 1'b1;
        base = st_cnt[0];
        repeat (10) @(negedge clock);
        check("rstmid_done_ignored_busy", {31'd0, busy[0]}, 32'd0);
        check("rstmid_done_ignored_start", st_cnt[0], base);
        rq.delete();
        en[0] = 1'b1;
        wait_busy(0, 1'b1, 20, cyc);
        en[0] = 1'b0;
        wait_busy(0, 1'b0, 300, cyc);
        check("resume_nreq", rq.size(), 4);
        if (rq.size() > 0) check("resume_erase0", {14'd0, rq[0]}, {14'd0, 1'b1, 9'd20, 8'd30});
        check("resume_origin", {15'd0, ox[0], oy[0]}, {15'd0, 9'd22, 8'd30});

        repeat (2000) @(negedge clock);
        check("inv_npass", npass[1], 2);
        if (npass[1] >= 2) begin
            check("inv_move1", {15'd0, hist[1][0]}, {15'd0, 9'd196, 8'd150});
            check("inv_move2_drop", {15'd0, hist[1][1]}, {15'd0, 9'd196, 8'd158});
        end
        check("inv_flag", {31'd0, inv[1]}, 32'd1);
        check("inv_halt_busy", {31'd0, busy[1]}, 32'd0);
        check("inv_nstart", st_cnt[1], 4);
        check("right_npass", {31'd0, npass[2] >= 3}, 32'd1);
        if (npass[2] >= 3) begin
            check("right_step", {15'd0, hist[2][0]}, {15'd0, 9'd196, 8'd30});
            check("right_bounce", {15'd0, hist[2][1]}, {15'd0, 9'd196, 8'd38});
            check("right_back", {15'd0, hist[2][2]}, {15'd0, 9'd194, 8'd38});
        end
        check("left_npass", {31'd0, npass[3] >= 3}, 32'd1);
        if (npass[3] >= 3) begin
            check("left_first_drop", {15'd0, hist[3][0]}, {15'd0, 9'd1, 8'd38});
            check("left_bounce", {15'd0, hist[3][1]}, {15'd0, 9'd1, 8'd46});
            check("left_back_right", {15'd0, hist[3][2]}, {15'd0, 9'd1, 8'd54});
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/enemy_formation_ctrl.md
Name: enemy_formation_ctrl

Overview:
Upstream sequencer for the per-enemy sprite drawer. It owns the formation origin and the march direction, and advances the formation at a fixed tick rate. On each tick it drives the drawer through two passes over the live enemies: an erase pass at the old positions, then a draw pass at the new positions, one request/done handshake per enemy. It also detects edge bounces and the invasion (bottom-reached) condition.

Parameters:
COLS, 8, enemies per row
ROWS, 4, rows in formation
SPACING_X, 16, pixel pitch between columns
SPACING_Y, 12, pixel pitch between rows
SPR_W, 12, sprite width in pixels
SPR_H, 8, sprite height in pixels
STEP, 2, horizontal pixels per move
DROP, 8, vertical pixels on bounce
X_MIN, 0, leftmost legal pixel
X_MAX, 319, rightmost legal pixel
Y_LIMIT, 200, invasion line; a formation bottom at or below this line ends the march
START_X, 20, reset origin x
START_Y, 30, reset origin y
MOVE_PERIOD, 1666666, clocks between moves (about 30 Hz at 50 MHz)

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
enable  in  1  march enable; tick counter frozen when 0
alive  in  ROWS*COLS  alive mask, bit idx = row*COLS+col
spr_x  out  9  sprite x for current request
spr_y  out  8  sprite y for current request
spr_erase  out  1  1 = draw in background colour (erase)
spr_start  out  1  one-cycle request pulse to drawer
spr_done  in  1  one-cycle completion pulse from drawer
origin_x  out  9  current formation origin x
origin_y  out  8  current formation origin y
busy  out  1  high in every state except IDLE and HALT
invaded  out  1  sticky; formation reached Y_LIMIT

Behaviour:
- Reset (async, resetn=0): state IDLE, origin=(START_X,START_Y), dir=right, tick counter=0, idx=0, snapshot=0, all outputs 0 except origin.
- Enemy position: x = origin_x + col*SPACING_X, y = origin_y + row*SPACING_Y. Computed at 9/8-bit width; parameters guarantee no overflow.
- IDLE: while enable=1, counter increments each clock. At MOVE_PERIOD-1: counter<=0, snapshot<=alive, idx<=0, go ERASE_ISSUE. enable=0 holds the counter.
- ERASE_ISSUE: if snapshot[idx]=0, idx++ (one clock per skipped slot). Otherwise drive spr_x/spr_y/spr_erase=1, pulse spr_start, go ERASE_WAIT. After idx=N-1 is handled, go MOVE.
- ERASE_WAIT: spr_x/y/erase held stable. On spr_done, idx++ and return to ERASE_ISSUE, or go MOVE if idx was N-1.
- MOVE (1 clock):
  - Right: if origin_x+(COLS-1)*SPACING_X+SPR_W-1+STEP > X_MAX, then origin_y+=DROP, dir<=left, x unchanged; else origin_x+=STEP.
  - Left: if origin_x < X_MIN+STEP, then origin_y+=DROP, dir<=right; else origin_x-=STEP.
  - Then idx<=0, go DRAW_ISSUE.
- DRAW_ISSUE/DRAW_WAIT: same as the erase pass with spr_erase=0. A slot is drawn only if snapshot[idx] & alive[idx], sampled at issue time, so an enemy killed mid-sequence is not redrawn.
- End of draw pass: if the new origin_y+(ROWS-1)*SPACING_Y+SPR_H-1 >= Y_LIMIT, set invaded=1 and go HALT; else go IDLE.
- HALT: terminal. Only reset exits. No spr_start is issued.
- spr_done outside the *_WAIT states is ignored. spr_start never fires while a request is outstanding.
- All-dead snapshot: both passes are skip-only (2*N clocks) and MOVE still occurs.

Test Plan:
- MOVE_PERIOD=4, alive=32'h5, enable=1 → after 4 clocks, erase requests at (20,30) and (52,30) with spr_erase=1, then draws at (22,30) and (54,30) with spr_erase=0; origin=(22,30); busy falls after the last spr_done.
- START_X=194 → first move gives origin_x=196 with no drop; next move gives a drop: origin=(196,38), dir=left; the following move gives origin_x=194.
- START_X=1, left direction forced via bounce → origin_x=1 < 2 causes a drop of 8 and dir=right, with no x underflow.
- START_Y=150 → move drop gives origin_y=158 (bottom 201 >= 200); after the draw pass invaded=1, state HALT, no further spr_start for 100 periods.
- Clear alive bit 2 during ERASE_WAIT of idx 0 (alive=32'h5) → idx 2 is still erased but not drawn; exactly 1 draw request is issued.
- resetn low mid DRAW_WAIT → spr_start=0, busy=0, origin=(20,30) immediately; a spr_done afterwards is ignored; normal march resumes after release.
